// File: rtl/alu16_result_stage.sv
// Result/status stage behind the 16-bit ALU: buffers Z and flags in a small FIFO,
// keeps sticky Carry/Overflow status and counts delivered results.
module alu16_result_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_z,
    input  logic [4:0]       in_flags,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_z,
    output logic [4:0]       out_flags,
    input  logic             sticky_clr,
    output logic [1:0]       sticky_cv,
    output logic [CNT_W-1:0] res_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    typedef enum logic {
        S_RESET,
        S_RUN
    } state_t;

    typedef struct packed {
        logic [15:0] z;
        logic [4:0]  flags;
    } entry_t;

    state_t             state_q, state_d;
    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [1:0]         sticky_q, sticky_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    // Readiness is held off for one edge after reset release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        full      = (occ_q == OCC_FULL);
        empty     = (occ_q == '0);
        in_ready  = (state_q == S_RUN) & ~full & ~flush;
        out_valid = ~empty;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;

        head      = mem_q[rd_ptr_q];
        out_z     = empty ? '0 : head.z;
        out_flags = empty ? '0 : head.flags;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end

        // Clear is applied before OR-ing in the pushed C/V.
        sticky_d = (sticky_clr ? 2'b00 : sticky_q)
                 | (push ? {in_flags[2], in_flags[0]} : 2'b00);
        cnt_d    = pop ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{z: in_z, flags: in_flags};
        end
    end

    assign sticky_cv = sticky_q;
    assign res_count = cnt_q;

endmodule

// File: tb/tb_alu16_result_stage.sv
// Directed self-checking bench for alu16_result_stage; a CNT_W=2 copy shares the stimulus
// so counter wrap is observed alongside the default instance.
module tb_alu16_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_z;
    logic [4:0]  in_flags;
    logic        flush;
    logic        out_ready;
    logic        sticky_clr;

    logic        in_ready,   w_in_ready;
    logic        out_valid,  w_out_valid;
    logic [15:0] out_z,      w_out_z;
    logic [4:0]  out_flags,  w_out_flags;
    logic [1:0]  sticky_cv,  w_sticky_cv;
    logic [7:0]  res_count;
    logic [1:0]  w_res_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [20:0] q[$];
    logic [1:0]  m_sticky;
    int unsigned m_cnt;
    logic        m_ready;
    logic        m_push;
    logic        m_pop;

    alu16_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z), .in_flags(in_flags),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
        .sticky_clr(sticky_clr), .sticky_cv(sticky_cv), .res_count(res_count)
    );

    alu16_result_stage #(.DEPTH(2), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_z(in_z), .in_flags(in_flags),
        .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_z(w_out_z), .out_flags(w_out_flags),
        .sticky_clr(sticky_clr), .sticky_cv(w_sticky_cv), .res_count(w_res_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] z, input logic [4:0] f);
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        chk({tag, "_z"}, 32'(out_z), 32'(z));
        chk({tag, "_flags"}, 32'(out_flags), 32'(f));
        chk({tag, "_w_valid"}, 32'(w_out_valid), 32'(v));
        chk({tag, "_w_z"}, 32'(w_out_z), 32'(z));
        chk({tag, "_w_flags"}, 32'(w_out_flags), 32'(f));
    endtask

    task automatic chk_rdy(input string tag, input logic r);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
        chk({tag, "_w_in_ready"}, 32'(w_in_ready), 32'(r));
    endtask

    task automatic chk_cnt(input string tag, input int unsigned n);
        chk({tag, "_count"}, 32'(res_count), 32'(n % 256));
        chk({tag, "_w_count"}, 32'(w_res_count), 32'(n % 4));
    endtask

    task automatic chk_sticky(input string tag, input logic [1:0] s);
        chk({tag, "_sticky"}, 32'(sticky_cv), 32'(s));
        chk({tag, "_w_sticky"}, 32'(w_sticky_cv), 32'(s));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_z = 16'h1234; in_flags = 5'b11111;
        flush = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;

        // Reset held with in_valid asserted
        #2;
        chk_rdy("rst_async", 1'b0);
        chk_out("rst_async", 1'b0, 16'h0, 5'h0);
        chk_cnt("rst_async", 0);
        chk_sticky("rst_async", 2'b00);
        tick(); tick();
        chk_rdy("rst_edge", 1'b0);
        chk_out("rst_edge", 1'b0, 16'h0, 5'h0);

        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk_rdy("rel_no_edge", 1'b0);
        tick();
        chk_rdy("rel_edge", 1'b1);
        chk_out("rel_edge", 1'b0, 16'h0, 5'h0);

        // Single push, latency 1
        in_valid = 1'b1; in_z = 16'h8000; in_flags = 5'b10101; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_out("single", 1'b1, 16'h8000, 5'b10101);
        chk_cnt("single", 0);
        chk_sticky("single", 2'b11);
        tick();
        chk_out("single_pop", 1'b0, 16'h0, 5'h0);
        chk_cnt("single_pop", 1);

        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk_sticky("clr_alone", 2'b00);

        // Fill with out_ready low, third push waits for a pop
        out_ready = 1'b0; in_valid = 1'b1; in_z = 16'h0001; in_flags = 5'b00000;
        tick();
        in_z = 16'h0002;
        tick();
        in_z = 16'h0003;
        #1;
        chk_rdy("full", 1'b0);
        chk_out("full", 1'b1, 16'h0001, 5'h0);
        tick();
        chk_rdy("full_hold", 1'b0);
        chk_out("full_hold", 1'b1, 16'h0001, 5'h0);
        out_ready = 1'b1;
        tick();
        chk_out("pop1", 1'b1, 16'h0002, 5'h0);
        chk_cnt("pop1", 2);
        chk_rdy("pop1", 1'b1);
        tick();
        in_valid = 1'b0;
        chk_out("pushpop", 1'b1, 16'h0003, 5'h0);
        chk_cnt("pushpop", 3);
        tick();
        chk_out("drain", 1'b0, 16'h0, 5'h0);
        chk_cnt("drain", 4);

        // Sticky accumulation and clear-with-push
        in_valid = 1'b1; in_z = 16'h0010; in_flags = 5'b00100;
        tick();
        in_z = 16'h0011; in_flags = 5'b00001;
        tick();
        in_valid = 1'b0;
        chk_sticky("sticky_or", 2'b11);
        chk_out("sticky_head", 1'b1, 16'h0011, 5'b00001);
        tick();
        chk_cnt("sticky_drain", 6);
        sticky_clr = 1'b1; in_valid = 1'b1; in_z = 16'h0012; in_flags = 5'b00001;
        tick();
        sticky_clr = 1'b0; in_valid = 1'b0;
        chk_sticky("clr_push", 2'b01);
        tick();
        chk_cnt("clr_push_pop", 7);
        chk_out("clr_push_pop", 1'b0, 16'h0, 5'h0);

        // Flush with two entries and out_ready high
        out_ready = 1'b0; in_valid = 1'b1; in_z = 16'h0020; in_flags = 5'b00100;
        tick();
        in_z = 16'h0021;
        tick();
        in_valid = 1'b0;
        chk_sticky("pre_flush", 2'b11);
        chk_out("pre_flush", 1'b1, 16'h0020, 5'b00100);
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        chk_out("flush2", 1'b0, 16'h0, 5'h0);
        chk_cnt("flush2", 8);
        chk_sticky("flush2", 2'b11);

        // Flush blocks a concurrent push
        in_valid = 1'b1; in_z = 16'h0030; in_flags = 5'b00000;
        tick();
        in_z = 16'h0031; flush = 1'b1;
        #1;
        chk_rdy("flush_blocks", 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk_out("flush1", 1'b0, 16'h0, 5'h0);
        chk_cnt("flush1", 8);
        tick();
        chk_out("flush1_after", 1'b0, 16'h0, 5'h0);

        // Counter wrap: narrow instance goes 1,2,3,0,1
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; out_ready = 1'b0; in_z = 16'h0040 + 16'(k); in_flags = 5'b00000;
            tick();
            in_valid = 1'b0; out_ready = 1'b1;
            tick();
            chk_cnt($sformatf("wrap%0d", k), 9 + k);
        end
        out_ready = 1'b0;

        // Mixed traffic against a queue model
        m_sticky = 2'b11;
        m_cnt = 13;
        for (int c = 0; c < 300; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            out_ready  = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 15) == 0);
            sticky_clr = ($urandom_range(0, 7) == 0);
            in_z       = 16'($urandom);
            in_flags   = 5'($urandom);
            #1;
            m_ready = !flush && (q.size() < 2);
            chk_rdy("mix", m_ready);
            m_push = in_valid && m_ready;
            m_pop  = (q.size() > 0) && out_ready;
            m_sticky = (sticky_clr ? 2'b00 : m_sticky) | (m_push ? {in_flags[2], in_flags[0]} : 2'b00);
            if (m_pop) begin
                void'(q.pop_front());
                m_cnt++;
            end
            if (flush) q.delete();
            else if (m_push) q.push_back({in_z, in_flags});
            tick();
            if (q.size() > 0) chk_out("mix", 1'b1, q[0][20:5], q[0][4:0]);
            else              chk_out("mix", 1'b0, 16'h0, 5'h0);
            chk_sticky("mix", m_sticky);
            chk_cnt("mix", m_cnt);
        end

        // Asynchronous reset mid-operation
        in_valid = 1'b1; flush = 1'b0; sticky_clr = 1'b0; out_ready = 1'b0;
        in_z = 16'h0055; in_flags = 5'b00101;
        tick();
        rst = 1'b1;
        #1;
        chk_rdy("mid_rst", 1'b0);
        chk_out("mid_rst", 1'b0, 16'h0, 5'h0);
        chk_cnt("mid_rst", 0);
        chk_sticky("mid_rst", 2'b00);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        chk_rdy("mid_rst_rel", 1'b1);
        chk_out("mid_rst_rel", 1'b0, 16'h0, 5'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
